// File: rtl/vx_pending_scoreboard.sv
// Per-(warp,reg) saturating pending-write scoreboard with multi-port retire and a 1-entry issue stage.
// Issue-to-out latency 1 cycle; ibuf_ready drops on an operand hazard or when the staged entry is held by out_ready=0.
module vx_pending_scoreboard #(
    parameter int NUM_WARPS    = 4,
    parameter int NUM_REGS     = 64,
    parameter int NUM_WB_PORTS = 2,
    parameter int MAX_PENDING  = 3,
    parameter int WAW_STALL    = 1,
    parameter int DATAW        = 128,
    parameter int TIMEOUT      = 10000,
    localparam int WIS_W       = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    localparam int RW          = $clog2(NUM_REGS)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          ibuf_valid,
    output logic                          ibuf_ready,
    input  logic [WIS_W-1:0]              ibuf_wis,
    input  logic                          ibuf_wb,
    input  logic [RW-1:0]                 ibuf_rd,
    input  logic [RW-1:0]                 ibuf_rs1,
    input  logic [RW-1:0]                 ibuf_rs2,
    input  logic [RW-1:0]                 ibuf_rs3,
    input  logic [DATAW-1:0]              ibuf_data,
    input  logic [NUM_WB_PORTS-1:0]       wb_valid,
    input  logic [NUM_WB_PORTS-1:0]       wb_eop,
    input  logic [NUM_WB_PORTS*WIS_W-1:0] wb_wis,
    input  logic [NUM_WB_PORTS*RW-1:0]    wb_rd,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATAW-1:0]              out_data,
    output logic [31:0]                   stall_cycles,
    output logic                          timeout,
    output logic                          err_underflow
);

    localparam int CNT_W = $clog2(MAX_PENDING + 1);
    localparam int ACC_W = CNT_W + $clog2(NUM_WB_PORTS) + 1;

    logic [CNT_W-1:0] cnt_q [NUM_WARPS][NUM_REGS];
    logic [CNT_W-1:0] cnt_d [NUM_WARPS][NUM_REGS];
    logic             out_valid_q, out_valid_d;
    logic [DATAW-1:0] out_data_q, out_data_d;
    logic [31:0]      stall_q, stall_d;
    logic             err_q, err_d;

    logic [WIS_W-1:0]        wb_wis_a [NUM_WB_PORTS];
    logic [RW-1:0]           wb_rd_a  [NUM_WB_PORTS];
    logic [NUM_WB_PORTS-1:0] retire;

    logic [CNT_W-1:0] c_rs1, c_rs2, c_rs3, c_rd;
    logic             rd_full, busy_rs, busy_rd, operands_ready, stg_ready, fire;
    logic [ACC_W-1:0] sum_tmp, dec_tmp;
    logic             underflow;

    for (genvar p = 0; p < NUM_WB_PORTS; p++) begin : g_wb
        assign wb_wis_a[p] = wb_wis[p*WIS_W +: WIS_W];
        assign wb_rd_a[p]  = wb_rd[p*RW +: RW];
    end

    // Only the last packet of a writeback retires the destination.
    assign retire = wb_valid & wb_eop;

    // Hazards look at registered counts only; a same-cycle retire does not unblock issue.
    assign c_rs1 = cnt_q[ibuf_wis][ibuf_rs1];
    assign c_rs2 = cnt_q[ibuf_wis][ibuf_rs2];
    assign c_rs3 = cnt_q[ibuf_wis][ibuf_rs3];
    assign c_rd  = cnt_q[ibuf_wis][ibuf_rd];

    if (WAW_STALL != 0) begin : g_waw_strict
        assign rd_full = (c_rd != '0);
    end else begin : g_waw_count
        assign rd_full = (c_rd == CNT_W'(MAX_PENDING));
    end

    assign busy_rs        = (c_rs1 != '0) | (c_rs2 != '0) | (c_rs3 != '0);
    assign busy_rd        = ibuf_wb & rd_full;
    assign operands_ready = ~busy_rs & ~busy_rd;
    assign stg_ready      = ~out_valid_q | out_ready;
    assign ibuf_ready     = operands_ready & stg_ready;
    assign fire           = ibuf_valid & ibuf_ready;

    always_comb begin
        cnt_d     = cnt_q;
        sum_tmp   = '0;
        dec_tmp   = '0;
        underflow = 1'b0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                sum_tmp = ACC_W'(cnt_q[w][r]);
                if (fire && ibuf_wb && (ibuf_wis == WIS_W'(w)) && (ibuf_rd == RW'(r))) begin
                    sum_tmp = sum_tmp + ACC_W'(1);
                end
                dec_tmp = '0;
                for (int p = 0; p < NUM_WB_PORTS; p++) begin
                    if (retire[p] && (wb_wis_a[p] == WIS_W'(w)) && (wb_rd_a[p] == RW'(r))) begin
                        dec_tmp = dec_tmp + ACC_W'(1);
                    end
                end
                // More retires than outstanding writes: clamp at zero and flag it.
                if (dec_tmp > sum_tmp) begin
                    cnt_d[w][r] = '0;
                    underflow   = 1'b1;
                end else begin
                    cnt_d[w][r] = CNT_W'(sum_tmp - dec_tmp);
                end
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        stall_d     = stall_q;
        err_d       = err_q | underflow;
        if (fire) begin
            out_valid_d = 1'b1;
            out_data_d  = ibuf_data;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
        if (fire) begin
            stall_d = '0;
        end else if (ibuf_valid && (stall_q != '1)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                for (int r = 0; r < NUM_REGS; r++) begin
                    cnt_q[w][r] <= '0;
                end
            end
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            stall_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            stall_q     <= stall_d;
            err_q       <= err_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_data      = out_data_q;
    assign stall_cycles  = stall_q;
    assign timeout       = (stall_q >= 32'(TIMEOUT));
    assign err_underflow = err_q;

endmodule
